// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and small op-decode helpers.
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // MULH, MULHSU, DIV and REM treat rs1 as signed
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Start/Done request bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface mdu_seq_if
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
);

    logic            Start_i;
    logic [2:0]      MDU_Operation_i;
    logic [XLEN-1:0] A_i;
    logic [XLEN-1:0] B_i;
    logic            Busy_o;
    logic            Done_o;
    logic [XLEN-1:0] Result_o;
    logic            Zero_o;

    modport master (
        output Start_i, MDU_Operation_i, A_i, B_i,
        input  Busy_o, Done_o, Result_o, Zero_o
    );

    modport slave (
        input  Start_i, MDU_Operation_i, A_i, B_i,
        output Busy_o, Done_o, Result_o, Zero_o
    );

endinterface

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Accumulator layout: {upper word, lower word}; the lower word starts as |A|.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic              mode_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   rem_sh_s;
    logic [XLEN-1:0] diff_s;

    // Compute both step flavours and pick the one for the current mode
    always_comb begin
        sum_s    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        rem_sh_s = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff_s   = rem_sh_s[XLEN-1:0] - opnd;
        if (mode_div) begin
            // remainder never exceeds 2*|B|, so the low XLEN bits of the difference suffice
            if (rem_sh_s >= {1'b0, opnd}) begin
                acc_next = {diff_s, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum_s, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide responder: accepts an op in IDLE, iterates
// XLEN radix-2 steps on operand magnitudes, then applies sign correction.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    mdu_seq_if.slave bus
);

    localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_W  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_r;
    logic [2:0]        op_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   opnd_r;
    logic              neg_q_r;
    logic              neg_a_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic              done_r;
    logic [XLEN-1:0]   result_r;

    logic              sa_s;
    logic              sb_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              fast_s;
    logic [XLEN-1:0]   fast_res_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res_s;

    // Decode incoming operands: sign flags, magnitudes and the no-iteration divide cases
    always_comb begin
        sa_s = op_a_signed(bus.MDU_Operation_i) & bus.A_i[XLEN-1];
        sb_s = op_b_signed(bus.MDU_Operation_i) & bus.B_i[XLEN-1];
        if (sa_s) begin
            mag_a_s = -bus.A_i;
        end else begin
            mag_a_s = bus.A_i;
        end
        if (sb_s) begin
            mag_b_s = -bus.B_i;
        end else begin
            mag_b_s = bus.B_i;
        end
        fast_s     = 1'b0;
        fast_res_s = ZERO_W;
        if (op_is_div(bus.MDU_Operation_i)) begin
            if (bus.B_i == ZERO_W) begin
                fast_s     = 1'b1;
                fast_res_s = op_is_rem(bus.MDU_Operation_i) ? bus.A_i : ONES_W;
            end else if (op_b_signed(bus.MDU_Operation_i) && (bus.A_i == MIN_W) && (bus.B_i == ONES_W)) begin
                fast_s     = 1'b1;
                fast_res_s = op_is_rem(bus.MDU_Operation_i) ? ZERO_W : MIN_W;
            end else begin
                fast_s     = 1'b0;
                fast_res_s = ZERO_W;
            end
        end else begin
            fast_s     = 1'b0;
            fast_res_s = ZERO_W;
        end
    end

    mdu_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .mode_div (op_r[2]),
        .acc      (acc_r),
        .opnd     (opnd_r),
        .acc_next (acc_next_s)
    );

    // Sign correction and result selection applied in FIX
    always_comb begin
        prod_s = neg_q_r ? -acc_r : acc_r;
        quo_s  = neg_q_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
        rem_s  = neg_a_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
        case (op_r)
            OP_MUL:                       fix_res_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res_s = quo_s;
            OP_REM, OP_REMU:              fix_res_s = rem_s;
            default:                      fix_res_s = ZERO_W;
        endcase
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            op_r     <= 3'b000;
            acc_r    <= {(2*XLEN){1'b0}};
            opnd_r   <= ZERO_W;
            neg_q_r  <= 1'b0;
            neg_a_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_W;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.Start_i) begin
                        op_r    <= bus.MDU_Operation_i;
                        neg_q_r <= sa_s ^ sb_s;
                        neg_a_r <= sa_s;
                        opnd_r  <= mag_b_s;
                        acc_r   <= {ZERO_W, mag_a_s};
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        if (fast_s) begin
                            result_r <= fast_res_s;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            state_r  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(XLEN - 1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    result_r <= fix_res_s;
                    done_r   <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy_o   = busy_r;
    assign bus.Done_o   = done_r;
    assign bus.Result_o = result_r;
    assign bus.Zero_o   = (result_r == ZERO_W);

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide responder for the RV32M extension in the single-cycle core.
- The core's execute stage issues an operation with A/B operands through a Start/Done handshake and stalls the PC while Busy_o is high.
- This is the sequential counterpart to the combinational ALU: the ALU completes add/sub/shift/logic in one cycle; this block completes MUL*/DIV*/REM* over several cycles.
- Its result is muxed with ALU_Result_o ahead of register-file write-back.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Start_i  input  1  request strobe; sampled only in IDLE.
- MDU_Operation_i  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A_i  input  XLEN  rs1 operand; signed or unsigned per op.
- B_i  input  XLEN  rs2 operand; signed or unsigned per op.
- Busy_o  output  1  high from the cycle after Start is accepted until Done_o.
- Done_o  output  1  one-cycle pulse; Result_o is valid in that cycle.
- Result_o  output  XLEN  registered result; holds until the next accepted Start.
- Zero_o  output  1  Result_o == 0, derived combinationally from the registered result.

Behaviour:
- Reset values: state IDLE, Busy_o=0, Done_o=0, Result_o=0, Zero_o=1, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - With Start_i=1: latch the op, |A|, |B| and the sign flags.
  - Fast-path divide (see Special cases): go to DONE.
  - Otherwise: counter=0, go to CALC.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add on the 64-bit product of magnitudes.
  - Divide: restoring shift-subtract producing quotient and remainder of magnitudes.
  - Leave after exactly XLEN steps (counter==XLEN-1), go to FIX.
- FIX:
  - Apply two's-complement correction.
    - Product negated iff the operand signs differ.
    - Quotient negated iff the signs differ.
    - Remainder takes the sign of the dividend.
  - Select the result: low word for MUL, high word for MULH*, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register Result_o and go to DONE.
- DONE: Done_o=1 for one cycle, then return to IDLE. A Start_i in this cycle is ignored.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Latency, with Start sampled in cycle 0:
  - Normal path: Busy_o=1 in cycles 1..34, Done_o=1 in cycle 34, Busy_o=0 from cycle 35.
  - Fast path: Done_o=1 and Busy_o=1 in cycle 1.
- Special cases (RISC-V spec; fast path, no CALC):
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU result = A_i.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- Start_i while Busy_o=1 is ignored; the in-flight operation is not disturbed.
- Operands and op are captured at acceptance; later changes on A_i, B_i and MDU_Operation_i have no effect.
- Reset asserted mid-operation: immediate return to reset values, no Done_o pulse.

Decomposition:
- Shared package mdu_pkg:
  - Localparams for the eight op codes, matching funct3.
  - State encoding IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - XLEN default.
- Sub-module mdu_iter_step: purely combinational, one radix-2 multiply/divide step.
  - Inputs: mode, partial accumulator, operand magnitude.
  - Output: next accumulator.
  - Instantiated once inside the FSM datapath.

Test Plan:
- MUL A=7, B=0xFFFFFFFD (-3), Start in cycle 0 -> Done_o in cycle 34, Result_o=0xFFFFFFEB, Zero_o=0, Busy_o low in cycle 35.
- MULH A=B=0x80000000 -> Result_o=0x40000000; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU A=100, B=0 -> Done_o in cycle 1, Result_o=0xFFFFFFFF. REMU A=100, B=0 -> 100. DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000 in cycle 1. REM same operands -> 0, Zero_o=1.
- Start a DIVU 100/7, pulse Start_i with MUL 3*3 in cycle 10 and change A_i -> Result_o=14 in cycle 34. No second Done_o unless Start_i is high in IDLE.
- Start MUL 5*5, assert reset in cycle 15 for one cycle -> Busy_o=0, Done_o=0, Result_o=0 immediately, no Done_o pulse afterwards. A new MUL 5*5 then yields 25 after 34 cycles.
